// File: rtl/ddr_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_mem_arbiter
//  Description : Two-master round-robin arbiter and access sequencer for a
//                single-port DDR memory model. Grants one request at a time,
//                issues a one-cycle wr/rd strobe, waits for the memory
//                response (with timeout) and returns read data and status
//                to the granted master.
//  Ports       : clk, reset            - clock, async active-high reset
//                mN_req/we/addr/wdata  - master N request side (N = 0,1)
//                mN_gnt/done/err/rdata - master N response side
//                mem_wr/rd/addr/wdata  - registered memory command
//                mem_rdata/rsp         - memory read data / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  // master 0
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  // master 1
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  // memory
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rsp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Counter value on which the last permitted WAIT cycle ends.
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            r_state, w_state_nxt;
  logic                  r_last,  w_last;
  logic                  r_cur,   w_cur;
  logic                  r_cur_we, w_cur_we;
  logic [7:0]            r_cnt,   w_cnt;
  logic [1:0]            r_gnt,   w_gnt;
  logic [1:0]            r_done,  w_done;
  logic [1:0]            r_err,   w_err;
  logic [DATA_WIDTH-1:0] r_rdata0, w_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1, w_rdata1;
  logic                  r_mem_wr, w_mem_wr;
  logic                  r_mem_rd, w_mem_rd;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;

  // Arbitration: a lone requester wins; on a tie the master not granted
  // last time wins (r_last resets to 1 so m0 takes the first tie).
  logic                  w_any;
  logic                  w_win;
  logic                  w_win_we;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_wdata;

  assign w_any       = m0_req | m1_req;
  assign w_win       = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_win_we    = w_win ? m1_we    : m0_we;
  assign w_win_addr  = w_win ? m1_addr  : m0_addr;
  assign w_win_wdata = w_win ? m1_wdata : m0_wdata;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_cur       <= 1'b0;
      r_cur_we    <= 1'b0;
      r_cnt       <= 8'd0;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_err       <= 2'b00;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last;
      r_cur       <= w_cur;
      r_cur_we    <= w_cur_we;
      r_cnt       <= w_cnt;
      r_gnt       <= w_gnt;
      r_done      <= w_done;
      r_err       <= w_err;
      r_rdata0    <= w_rdata0;
      r_rdata1    <= w_rdata1;
      r_mem_wr    <= w_mem_wr;
      r_mem_rd    <= w_mem_rd;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_rsp || (r_cnt == c_TMO_LAST)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values (all outputs are registered from these)
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt       = 2'b00;
    w_done      = 2'b00;
    w_err       = 2'b00;
    w_mem_wr    = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_cur       = r_cur;
    w_cur_we    = r_cur_we;
    w_last      = r_last;
    w_cnt       = r_cnt;
    w_rdata0    = r_rdata0;
    w_rdata1    = r_rdata1;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt[w_win] = 1'b1;
          w_mem_wr     = w_win_we;
          w_mem_rd     = ~w_win_we;
          w_mem_addr   = w_win_addr;
          w_mem_wdata  = w_win_wdata;
          w_cur        = w_win;
          w_cur_we     = w_win_we;
          w_last       = w_win;
        end
      end
      S_ISSUE: begin
        w_cnt = 8'd0;
      end
      S_WAIT: begin
        if (mem_rsp) begin
          w_done[r_cur] = 1'b1;
          if (!r_cur_we) begin
            if (r_cur) w_rdata1 = mem_rdata;
            else       w_rdata0 = mem_rdata;
          end
        end else if (r_cnt == c_TMO_LAST) begin
          // Timeout: flag the error, leave read data untouched.
          w_done[r_cur] = 1'b1;
          w_err[r_cur]  = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign m0_gnt    = r_gnt[0];
  assign m1_gnt    = r_gnt[1];
  assign m0_done   = r_done[0];
  assign m1_done   = r_done[1];
  assign m0_err    = r_err[0];
  assign m1_err    = r_err[1];
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign mem_wr    = r_mem_wr;
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
